// File: rtl/mp_addsub_seq_if.sv
// ----------------------------------------------------------------------------
// mp_addsub_seq_if
// Operand and result streams of the multi-precision add/subtract sequencer.
//
//   in_valid   operand pair valid (front-end -> sequencer)
//   in_ready   sequencer accepts the pair this cycle
//   in_a       operand A word, least-significant word first
//   in_b       operand B word, least-significant word first
//   out_valid  sum word valid (sequencer -> downstream)
//   out_ready  downstream accepts the sum word
//   out_sum    sum word
//   out_last   out_sum is the most-significant word of the result
//
// master: the ALU front-end / downstream side that feeds operands and
//         drains sums.
// slave:  the sequencer itself.
// ----------------------------------------------------------------------------
interface mp_addsub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_last;

    modport master (
        output in_valid,
        input  in_ready,
        output in_a,
        output in_b,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_a,
        input  in_b,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_last
    );
endinterface

// File: rtl/mp_addsub_seq.sv
// ----------------------------------------------------------------------------
// mp_addsub_seq
// Multi-precision add/subtract sequencer for a shared external 32-bit ADC
// adder (S = A + B + C0, 33-bit result). Operands stream in one 32-bit word
// pair per cycle, least-significant word first; the carry is chained from
// word to word and one sum word is returned per input pair.
//
// Parameters
//   CNT_W      width of the word count; longest operand is 2**CNT_W-1 words
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin an operation (only looked at in IDLE)
//   sub        0: A+B, 1: A-B (captured at start)
//   nwords     operand length in words (captured at start, 0 is ignored)
//   busy       high while an operation is in RUN or FLUSH
//   carry_out  final carry (subtract: 1 = no borrow), valid from done
//   overflow   signed overflow of the most-significant word, valid from done
//   done       one-cycle pulse in the cycle the last sum word is accepted
//   adc_a      adder operand A
//   adc_b      adder operand B (inverted for subtract)
//   adc_c0     adder carry-in
//   adc_s      adder result, combinational from adc_a/adc_b/adc_c0
//   bus        operand/result streams (slave side)
// ----------------------------------------------------------------------------
module mp_addsub_seq #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [CNT_W-1:0] nwords,
    output logic             busy,
    output logic             carry_out,
    output logic             overflow,
    output logic             done,
    output logic [31:0]      adc_a,
    output logic [31:0]      adc_b,
    output logic             adc_c0,
    input  logic [32:0]      adc_s,
    mp_addsub_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             sub_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic [31:0]      out_sum_q;
    logic             out_last_q;

    logic             in_ready;
    logic             accept;
    logic             pop;
    logic             start_ok;
    logic             last_word;

    assign last_word     = (cnt == CNT_W'(1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_last  = out_last_q;

    // State register. An asynchronous reset drops straight back to IDLE,
    // which is what makes a mid-operation reset abort silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode. The output register holds a single
    // word, so a new pair can be taken whenever that register is empty or
    // is being drained in the same cycle; this gives one word per cycle
    // while out_ready stays high. The adder is only driven while an
    // operation is in flight so it sees all-zero inputs when idle.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        in_ready = 1'b0;
        accept   = 1'b0;
        start_ok = 1'b0;
        done     = 1'b0;
        adc_a    = 32'd0;
        adc_b    = 32'd0;
        adc_c0   = 1'b0;
        pop      = out_valid_q && bus.out_ready;

        case (state_q)
            IDLE: begin
                if (start && (nwords != '0)) begin
                    start_ok = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                adc_a    = bus.in_a;
                adc_b    = sub_q ? ~bus.in_b : bus.in_b;
                adc_c0   = carry;
                in_ready = !out_valid_q || bus.out_ready;
                accept   = bus.in_valid && in_ready;
                if (accept && last_word) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                busy   = 1'b1;
                adc_a  = bus.in_a;
                adc_b  = sub_q ? ~bus.in_b : bus.in_b;
                adc_c0 = carry;
                if (pop && out_last_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers. A subtract starts with carry=1 so that A + ~B + 1
    // forms A - B; only adc_s[32] is carried into the next word. The final
    // carry and the signed overflow of the top word are captured on the
    // last accept and held until the next operation starts. When a new word
    // is accepted in the same cycle the old one is drained, the new word
    // simply replaces it and out_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q       <= 1'b0;
            carry       <= 1'b0;
            cnt         <= '0;
            out_sum_q   <= 32'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (start_ok) begin
                sub_q     <= sub;
                cnt       <= nwords;
                carry     <= sub;
                carry_out <= 1'b0;
                overflow  <= 1'b0;
            end

            if (accept) begin
                out_sum_q   <= adc_s[31:0];
                carry       <= adc_s[32];
                out_valid_q <= 1'b1;
                cnt         <= cnt - CNT_W'(1);
                out_last_q  <= last_word;
                if (last_word) begin
                    carry_out <= adc_s[32];
                    overflow  <= (bus.in_a[31] == adc_b[31]) &&
                                 (adc_s[31] != bus.in_a[31]);
                end
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
